// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor computing diff = a - b - bin (mod 2^WIDTH) and the
// unsigned borrow-out, one bit per clock, LSB first, through a single 1-bit
// full-subtractor cell. A three-state FSM (IDLE -> RUN -> DONE) sequences
// the operation; a result takes WIDTH cycles and is presented with a
// one-cycle done pulse.
//
// Ports:
//   clk    in   1      clock, rising edge active
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request a subtraction (accepted in IDLE or DONE)
//   a      in   WIDTH  minuend, captured on the accepting edge only
//   b      in   WIDTH  subtrahend, captured on the accepting edge only
//   bin    in   1      borrow-in, captured on the accepting edge only
//   diff   out  WIDTH  registered difference, held until the next result
//   bout   out  1      registered borrow-out (a < b + bin, unsigned)
//   busy   out  1      high while the FSM is in RUN
//   done   out  1      high for the single cycle the FSM is in DONE
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;

    // Full-subtractor cell on the current LSBs and borrow.
    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [CW-1:0]    cnt_d;

    always_comb begin
        d_bit = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
        // New bit enters at the MSB; after WIDTH shifts bit 0 of the
        // result sits at bit 0 of the register.
        res_d = WIDTH'({d_bit, res_q} >> 1);
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here.
                    a_q   <= a_d;
                    b_q   <= b_d;
                    br_q  <= br_d;
                    res_q <= res_d;
                    if (cnt_q == LAST_BIT) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
